// File: rtl/fps_link_pkg.sv
// Shared definitions for the link multiplexer and its stale-node tracker.
// Link/node/interlock geometry, derived widths, and acq_index(), which maps
// a (link, node) pair onto the flat node numbering used by the mitigation stage.
package fps_link_pkg;

    localparam int MAX_LINK_COUNT      = 4;
    localparam int NODES_PER_LINK      = 16;
    localparam int INTERLOCKS_PER_NODE = 64;
    localparam int ACQ_INDEX_WIDTH     = 6;

    localparam int NODE_COUNT = MAX_LINK_COUNT * NODES_PER_LINK;
    localparam int LINK_WIDTH = (MAX_LINK_COUNT > 1) ? $clog2(MAX_LINK_COUNT) : 1;
    // One code wider than a legal node index needs, so the raw receiver field
    // can carry out-of-range values (e.g. 16) that must be counted and dropped.
    localparam int NODE_WIDTH = $clog2(NODES_PER_LINK + 1);

    function automatic logic [ACQ_INDEX_WIDTH-1:0] acq_index(
        input logic [LINK_WIDTH-1:0] link,
        input logic [NODE_WIDTH-1:0] node
    );
        return ACQ_INDEX_WIDTH'(int'(link) * NODES_PER_LINK + int'(node));
    endfunction

endpackage

// File: rtl/fps_stale_tracker.sv
// Per-node age tracking for fps_link_mux.
// A prescaler produces one tick every TICK_CYCLES clocks; each tick ages every
// node that has not yet saturated. A good accept resets its node's age (and
// beats a coincident tick). A link that is down holds all its nodes saturated.
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   accept_valid    a good (in-range) packet is accepted this cycle
//   accept_index    flat node index of that packet
//   link_up         per-link channel-up
//   stale_nodes     registered: bit k set while node k's age is saturated
module fps_stale_tracker
    import fps_link_pkg::*;
#(
    parameter int TICK_CYCLES = 1250,
    parameter int AGE_WIDTH   = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       accept_valid,
    input  logic [ACQ_INDEX_WIDTH-1:0] accept_index,
    input  logic [MAX_LINK_COUNT-1:0]  link_up,
    output logic [NODE_COUNT-1:0]      stale_nodes
);

    localparam int PRESC_WIDTH = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [PRESC_WIDTH-1:0] PRESC_RELOAD = PRESC_WIDTH'(TICK_CYCLES - 1);
    localparam logic [AGE_WIDTH-1:0]   AGE_MAX      = {AGE_WIDTH{1'b1}};

    logic [PRESC_WIDTH-1:0] prescaler;
    logic                   tick;

    assign tick = (prescaler == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prescaler <= PRESC_RELOAD;
        end else if (tick) begin
            prescaler <= PRESC_RELOAD;
        end else begin
            prescaler <= prescaler - PRESC_WIDTH'(1);
        end
    end

    for (genvar k = 0; k < NODE_COUNT; k++) begin : g_node
        localparam int LINK = k / NODES_PER_LINK;
        localparam logic [ACQ_INDEX_WIDTH-1:0] INDEX = ACQ_INDEX_WIDTH'(k);

        logic [AGE_WIDTH-1:0] age;
        logic                 stale_q;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                age     <= AGE_MAX;
                stale_q <= 1'b1;
            end else begin
                stale_q <= (age == AGE_MAX);
                if (!link_up[LINK]) begin
                    age <= AGE_MAX;
                end else if (accept_valid && (accept_index == INDEX)) begin
                    age <= '0;
                end else if (tick && (age != AGE_MAX)) begin
                    age <= age + AGE_WIDTH'(1);
                end
            end
        end

        assign stale_nodes[k] = stale_q;
    end

endmodule

// File: rtl/fps_link_mux.sv
// Merges node-report packets from MAX_LINK_COUNT link receivers into the
// single report stream of the mitigation stage, with round-robin arbitration
// (one accept per clock), a one-cycle registered output, an out-of-range
// node counter, and per-node staleness tracking.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   linkUp/linkValid           per-link channel-up and packet valid
//   linkReady                  per-link accept (one-hot grant, combinational)
//   linkNode/linkState/linkTransitions   flattened per-link packet fields
//   newDataStrobe              one-cycle pulse: acqIndex/inputState/inputTransitions are new
//   staleNodes                 bit per flat node index, set = node stale
//   badNodeCount               saturating count of dropped out-of-range packets
// Build option FPS_LINK_MUX_STATS_EN: adds statsClear input and
// linkPacketCount output (per-link 32-bit wrapping count of all accepts).
module fps_link_mux
    import fps_link_pkg::*;
#(
    parameter int STALE_TICK_CYCLES = 1250,
    parameter int STALE_AGE_WIDTH   = 3
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic [MAX_LINK_COUNT-1:0]                     linkUp,
    input  logic [MAX_LINK_COUNT-1:0]                     linkValid,
    output logic [MAX_LINK_COUNT-1:0]                     linkReady,
    input  logic [MAX_LINK_COUNT*NODE_WIDTH-1:0]          linkNode,
    input  logic [MAX_LINK_COUNT*INTERLOCKS_PER_NODE-1:0] linkState,
    input  logic [MAX_LINK_COUNT*INTERLOCKS_PER_NODE-1:0] linkTransitions,
    output logic                                          newDataStrobe,
    output logic [ACQ_INDEX_WIDTH-1:0]                    acqIndex,
    output logic [INTERLOCKS_PER_NODE-1:0]                inputState,
    output logic [INTERLOCKS_PER_NODE-1:0]                inputTransitions,
    output logic [NODE_COUNT-1:0]                         staleNodes,
    output logic [15:0]                                   badNodeCount
`ifdef FPS_LINK_MUX_STATS_EN
    ,
    input  logic                                          statsClear,
    output logic [MAX_LINK_COUNT*32-1:0]                  linkPacketCount
`endif
);

    if (ACQ_INDEX_WIDTH != $clog2(NODE_COUNT)) begin : g_acq_width_check
        $error("ACQ_INDEX_WIDTH must equal $clog2(MAX_LINK_COUNT*NODES_PER_LINK)");
    end

    logic [MAX_LINK_COUNT-1:0]      eligible;
    logic [LINK_WIDTH-1:0]          rr_ptr;
    logic [LINK_WIDTH-1:0]          cand;
    logic [LINK_WIDTH-1:0]          grant_idx;
    logic                           grant_valid;
    logic [NODE_WIDTH-1:0]          grant_node;
    logic                           node_ok;
    logic                           good_accept;
    logic [ACQ_INDEX_WIDTH-1:0]     grant_acq;

    // Down links are never eligible, which also keeps their linkReady low.
    assign eligible = linkValid & linkUp;

    always_comb begin
        cand        = '0;
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < MAX_LINK_COUNT; k++) begin
            cand = LINK_WIDTH'((int'(rr_ptr) + k) % MAX_LINK_COUNT);
            if (!grant_valid && eligible[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        linkReady = '0;
        if (grant_valid) begin
            linkReady[grant_idx] = 1'b1;
        end
    end

    assign grant_node  = linkNode[int'(grant_idx)*NODE_WIDTH +: NODE_WIDTH];
    assign node_ok     = (int'(grant_node) < NODES_PER_LINK);
    assign good_accept = grant_valid && node_ok;
    assign grant_acq   = acq_index(grant_idx, grant_node);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr           <= '0;
            newDataStrobe    <= 1'b0;
            acqIndex         <= '0;
            inputState       <= '0;
            inputTransitions <= '0;
            badNodeCount     <= '0;
        end else begin
            newDataStrobe <= good_accept;
            if (grant_valid) begin
                rr_ptr <= LINK_WIDTH'((int'(grant_idx) + 1) % MAX_LINK_COUNT);
            end
            if (good_accept) begin
                acqIndex         <= grant_acq;
                inputState       <= linkState[int'(grant_idx)*INTERLOCKS_PER_NODE +: INTERLOCKS_PER_NODE];
                inputTransitions <= linkTransitions[int'(grant_idx)*INTERLOCKS_PER_NODE +: INTERLOCKS_PER_NODE];
            end
            if (grant_valid && !node_ok && (badNodeCount != 16'hFFFF)) begin
                badNodeCount <= badNodeCount + 16'd1;
            end
        end
    end

    fps_stale_tracker #(
        .TICK_CYCLES (STALE_TICK_CYCLES),
        .AGE_WIDTH   (STALE_AGE_WIDTH)
    ) u_stale (
        .clk          (clk),
        .reset        (reset),
        .accept_valid (good_accept),
        .accept_index (grant_acq),
        .link_up      (linkUp),
        .stale_nodes  (staleNodes)
    );

`ifdef FPS_LINK_MUX_STATS_EN
    logic [31:0] pkt_count [MAX_LINK_COUNT];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < MAX_LINK_COUNT; i++) pkt_count[i] <= '0;
        end else if (statsClear) begin
            for (int i = 0; i < MAX_LINK_COUNT; i++) pkt_count[i] <= '0;
        end else if (grant_valid) begin
            pkt_count[grant_idx] <= pkt_count[grant_idx] + 32'd1;
        end
    end

    for (genvar i = 0; i < MAX_LINK_COUNT; i++) begin : g_stats
        assign linkPacketCount[i*32 +: 32] = pkt_count[i];
    end
`endif

endmodule

// File: tb/tb_fps_link_mux.sv
module tb_fps_link_mux;
    import fps_link_pkg::*;

    localparam int P     = 4;
    localparam int W     = 3;
    localparam int LIMIT = (1 << W) - 1;
    localparam int L     = MAX_LINK_COUNT;
    localparam int N     = NODES_PER_LINK;
    localparam int I     = INTERLOCKS_PER_NODE;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [L-1:0]          linkUp, linkValid, linkReady;
    logic [L*NODE_WIDTH-1:0] linkNode;
    logic [L*I-1:0]        linkState, linkTransitions;
    logic                  newDataStrobe;
    logic [ACQ_INDEX_WIDTH-1:0] acqIndex;
    logic [I-1:0]          inputState, inputTransitions;
    logic [NODE_COUNT-1:0] staleNodes;
    logic [15:0]           badNodeCount;
`ifdef FPS_LINK_MUX_STATS_EN
    logic                  statsClear;
    logic [L*32-1:0]       linkPacketCount;
`endif

    fps_link_mux #(.STALE_TICK_CYCLES(P), .STALE_AGE_WIDTH(W)) dut (
        .clk(clk), .reset(reset), .linkUp(linkUp), .linkValid(linkValid),
        .linkReady(linkReady), .linkNode(linkNode), .linkState(linkState),
        .linkTransitions(linkTransitions), .newDataStrobe(newDataStrobe),
        .acqIndex(acqIndex), .inputState(inputState), .inputTransitions(inputTransitions),
        .staleNodes(staleNodes), .badNodeCount(badNodeCount)
`ifdef FPS_LINK_MUX_STATS_EN
        , .statsClear(statsClear), .linkPacketCount(linkPacketCount)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [5:0]  acq;
        logic [63:0] st;
        logic [63:0] tr;
    } exp_t;

    exp_t        sbq[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          mon_cyc = 0;
    int          m_rr = 0;
    int          m_bad = 0;
    int          m_ticks [NODE_COUNT];   // tick periods since last report, capped
    logic [63:0] m_stale = '1;
    bit   [31:0] m_pkt [L];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Reference model: evaluated mid-cycle with inputs stable, it checks the
    // registered outputs, predicts this cycle's grant, then advances.
    always @(negedge clk) begin
        int          g;
        int          node;
        int          acq;
        bit          tick;
        logic [63:0] nxt_stale;
        exp_t        e;
        if (!reset) begin
            check("staleNodes", staleNodes, m_stale);
            check("badNodeCount", 64'(badNodeCount), 64'(m_bad));
`ifdef FPS_LINK_MUX_STATS_EN
            for (int i = 0; i < L; i++)
                check("linkPacketCount", 64'(linkPacketCount[i*32 +: 32]), 64'(m_pkt[i]));
`endif
            g = -1;
            for (int off = 0; off < L; off++) begin
                int li;
                li = (m_rr + off) % L;
                if (g < 0 && linkUp[li] && linkValid[li]) g = li;
            end
            check("linkReady", 64'(linkReady), (g >= 0) ? (64'd1 << g) : 64'd0);

            tick = ((cyc % P) == P - 1);
            for (int k = 0; k < NODE_COUNT; k++) nxt_stale[k] = (m_ticks[k] >= LIMIT);
            acq = -1;
            if (g >= 0) begin
                node = int'(linkNode[g*NODE_WIDTH +: NODE_WIDTH]);
                m_rr = (g + 1) % L;
                m_pkt[g] = m_pkt[g] + 32'd1;
                if (node < N) begin
                    acq   = g * N + node;
                    e.due = cyc + 1;
                    e.acq = 6'(acq);
                    e.st  = linkState[g*I +: I];
                    e.tr  = linkTransitions[g*I +: I];
                    sbq.push_back(e);
                end else if (m_bad < 65535) begin
                    m_bad++;
                end
            end
            for (int k = 0; k < NODE_COUNT; k++) begin
                if (!linkUp[k / N])                       m_ticks[k] = LIMIT;
                else if (k == acq)                        m_ticks[k] = 0;
                else if (tick && m_ticks[k] < LIMIT)      m_ticks[k]++;
            end
            m_stale = nxt_stale;
            cyc++;
        end
    end

    // Monitor: every strobe must match the oldest expected report and its due cycle.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (newDataStrobe) begin
                if (sbq.size() == 0) begin
                    check("unexpected_strobe", 64'd1, 64'd0);
                end else begin
                    e = sbq.pop_front();
                    check("strobe_latency", 64'(mon_cyc), 64'(e.due));
                    check("acqIndex", 64'(acqIndex), 64'(e.acq));
                    check("inputState", inputState, e.st);
                    check("inputTransitions", inputTransitions, e.tr);
                end
            end else if (sbq.size() > 0 && sbq[0].due <= mon_cyc) begin
                check("missing_strobe", 64'(sbq[0].due), 64'(mon_cyc + 1));
                void'(sbq.pop_front());
            end
            mon_cyc++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pkt(input int link, input int node, input logic [63:0] st, input logic [63:0] tr);
        linkValid[link]                       = 1'b1;
        linkNode[link*NODE_WIDTH +: NODE_WIDTH] = NODE_WIDTH'(node);
        linkState[link*I +: I]                = st;
        linkTransitions[link*I +: I]          = tr;
    endtask

    initial begin
        for (int k = 0; k < NODE_COUNT; k++) m_ticks[k] = LIMIT;
        for (int i = 0; i < L; i++) m_pkt[i] = '0;
        reset = 1'b1;
        linkUp = '1;
        linkValid = '0;
        linkNode = '0;
        linkState = '0;
        linkTransitions = '0;
`ifdef FPS_LINK_MUX_STATS_EN
        statsClear = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Idle after reset
        step(); step();

        // Two links contend: link0 node3 first, then link2 node5
        set_pkt(0, 3, 64'h0123_4567_89AB_CDEF, 64'h1);
        set_pkt(2, 5, 64'hFEDC_BA98_7654_3210, 64'h2);
        step();
        linkValid[0] = 1'b0;
        step();
        linkValid = '0;
        step(); step();

        // Single report from link1 node7, then silence long enough to go stale
        set_pkt(1, 7, 64'hA5A5, 64'h5A5A);
        step();
        linkValid = '0;
        repeat (40) step();

        // Report landing exactly on a tick cycle
        while ((cyc % P) != P - 1) step();
        set_pkt(1, 7, 64'hBEEF, 64'hCAFE);
        step();
        linkValid = '0;
        repeat (6) step();

        // Link3 drops while offering a packet
        set_pkt(3, 2, 64'h33, 64'h44);
        linkUp[3] = 1'b0;
        repeat (3) step();
        linkValid = '0;
        linkUp[3] = 1'b1;
        step();

        // Out-of-range node index on link1
        set_pkt(1, 16, 64'h77, 64'h88);
        step();
        linkValid = '0;
        repeat (3) step();

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < L; i++) begin
                linkUp[i]    = ($urandom_range(0, 31) != 0);
                linkValid[i] = ($urandom_range(0, 2) != 0);
                linkNode[i*NODE_WIDTH +: NODE_WIDTH] = NODE_WIDTH'($urandom_range(0, N + 1));
                linkState[i*I +: I]       = {$urandom, $urandom};
                linkTransitions[i*I +: I] = {$urandom, $urandom};
            end
            step();
        end
        linkValid = '0;
        linkUp = '1;
        repeat (5) step();

        check("scoreboard_drained", 64'(sbq.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
